// File: rtl/clock_ratio_meter.sv
// Measures period and high time of a slow same-domain strobe in clk cycles; flags lock and timeout.
// Latency: a rise sampled at edge t updates period/highTime/measValid/locked/timeout at edge t.
// Backpressure: none; measValid is a single-cycle pulse with no ready handshake.
module clock_ratio_meter #(
    parameter int MAX_PERIOD = 256,
    parameter int LOCK_COUNT = 4,
    localparam int W = $clog2(MAX_PERIOD + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sigIn,
    output logic [W-1:0] period,
    output logic [W-1:0] highTime,
    output logic         measValid,
    output logic         locked,
    output logic         timeout
);

    localparam int MW = $clog2(LOCK_COUNT);
    localparam logic [W-1:0]  CNT_MAX   = W'(MAX_PERIOD);
    localparam logic [MW-1:0] MATCH_TOP = MW'(LOCK_COUNT - 1);

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t        state;
    logic [W-1:0]  cnt;
    logic [W-1:0]  hiLatch;
    logic [MW-1:0] matchCnt;
    logic [MW-1:0] matchNxt;
    logic          sigD;
    logic          havePrev;
    logic          rise;
    logic          fall;

    assign rise = sigIn & ~sigD;
    assign fall = ~sigIn & sigD;

    // Run length of identical periods, saturating one short of LOCK_COUNT.
    always_comb begin
        matchNxt = '0;
        if (havePrev && (cnt == period)) begin
            matchNxt = (matchCnt == MATCH_TOP) ? matchCnt : matchCnt + MW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            hiLatch   <= '0;
            matchCnt  <= '0;
            havePrev  <= 1'b0;
            sigD      <= 1'b1;
            period    <= '0;
            highTime  <= '0;
            measValid <= 1'b0;
            locked    <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            sigD      <= sigIn;
            measValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        cnt     <= W'(1);
                        timeout <= 1'b0;
                        state   <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period    <= cnt;
                        highTime  <= hiLatch;
                        measValid <= 1'b1;
                        cnt       <= W'(1);
                        timeout   <= 1'b0;
                        matchCnt  <= matchNxt;
                        locked    <= (matchNxt == MATCH_TOP);
                        havePrev  <= 1'b1;
                    end else if (cnt == CNT_MAX) begin
                        // Rise has priority above, so a period of exactly MAX_PERIOD still measures.
                        state    <= IDLE;
                        cnt      <= '0;
                        timeout  <= 1'b1;
                        locked   <= 1'b0;
                        matchCnt <= '0;
                        havePrev <= 1'b0;
                    end else begin
                        cnt <= cnt + W'(1);
                        if (fall) begin
                            hiLatch <= cnt;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/clock_ratio_meter.md
Name: clock_ratio_meter

Overview:
- Receive-side companion to the team's clock divider: samples a slow divided clock in the fast `clk` domain.
- Measures the divided clock's period and high time in `clk` cycles and reports them once per period with a valid pulse.
- Flags lock when the period is stable and flags timeout when edges stop.
- Used as a self-check monitor on divider outputs and as a ratio detector for any same-domain slow strobe.

Parameters:
- MAX_PERIOD, 256, largest measurable period in clk cycles; also the timeout threshold.
- LOCK_COUNT, 4, number of consecutive equal period measurements required to assert `locked` (min 2).
- W, $clog2(MAX_PERIOD+1), derived width of the count outputs; not to be overridden.

Ports:
- clk  input  1  system clock; same domain that generates sigIn.
- rst  input  1  synchronous, active-high reset.
- sigIn  input  1  divided clock under measurement, synchronous to clk.
- period  output  W  last measured rise-to-rise interval, in clk cycles.
- highTime  output  W  high phase (rise-to-fall) of the period reported in `period`.
- measValid  output  1  one-cycle pulse; period/highTime updated this cycle.
- locked  output  1  LOCK_COUNT consecutive identical periods seen.
- timeout  output  1  no rising edge within MAX_PERIOD cycles; sticky until the next rise.

Behaviour:
- Reset (rst high at a clk edge): period=0, highTime=0, measValid=0, locked=0, timeout=0, state=IDLE, cnt=0, matchCnt=0, sigD=1. sigD resets to 1 so a sigIn already high after reset is not treated as a rise.
- Edge detect: sigD <= sigIn every cycle; rise = sigIn & ~sigD; fall = ~sigIn & sigD. Both are combinational and are acted on at the next edge.
- IDLE: ignore fall; cnt holds 0. On rise: cnt <= 1, go to MEASURE, no measValid.
- MEASURE, cycle with no rise: cnt <= cnt+1, saturating at MAX_PERIOD. On fall: hiLatch <= cnt.
- MEASURE, rise cycle:
  - period <= cnt; highTime <= hiLatch; measValid <= 1 (visible the following cycle); cnt <= 1; timeout <= 0.
  - If new cnt == previous period and a previous measurement exists: matchCnt <= min(matchCnt+1, LOCK_COUNT-1). Otherwise matchCnt <= 0.
  - locked <= (updated matchCnt == LOCK_COUNT-1). A mismatching period deasserts locked in the same update.
- Latency: outputs reflect a rise detected in cycle t at cycle t+1. measValid is high for exactly one cycle per measured period.
- Timeout: in MEASURE, if cnt == MAX_PERIOD and there is no rise this cycle, then go to IDLE, timeout <= 1, locked <= 0, matchCnt <= 0, and clear the previous-measurement flag. period/highTime hold their last values.
- Simultaneous rise and timeout condition: rise wins, so a period of exactly MAX_PERIOD is measured normally.
- No fall between two rises is impossible for a 1-bit signal. If sigIn falls before the first fall-capture after a rise, hiLatch holds the last captured value.
- Arithmetic: all counts unsigned W bits. cnt never exceeds MAX_PERIOD, so there is no wrap-around.
- Reset mid-measurement: all state clears and measurement restarts from IDLE. The first post-reset period never produces measValid.
- Divider reference values (sigIn = divider output with DIVISOR=D):
  - period = D.
  - highTime = D - floor(D/2).
  - Worked cases: D=2 gives 2/1, D=3 gives 3/2, D=4 gives 4/2, D=5 gives 5/3.

Test Plan:
- Divider D=4 drives sigIn from reset -> first measValid on the second rise; period=4, highTime=2 every 4 cycles; locked rises on the 4th equal measurement (LOCK_COUNT=4).
- Divider D=5 (odd) -> period=5, highTime=3; measValid spacing exactly 5 cycles; locked after 4 measurements.
- Locked at D=4, then the stimulus switches to D=3 -> the first period=3 report drops locked in the same cycle as its measValid; locked returns after 4 equal periods of 3.
- sigIn held low after lock, MAX_PERIOD=16 -> timeout=1 and locked=0 exactly when cnt hits 16; no measValid. The next two rises give no report on the first and a valid report on the second; timeout clears on the first rise.
- Rise landing exactly at cnt==MAX_PERIOD (period 16, MAX_PERIOD=16) -> measValid with period=16 and no timeout.
- rst asserted for 1 cycle mid-period with sigIn high, then released -> all outputs 0 the following cycle; no false rise while sigIn stays high; the first measValid comes only after two subsequent rises.
